// File: rtl/round_arbiter.sv
// Two-player round controller: IDLE -> COUNT -> ANSWER -> RESULT -> IDLE.
// Optional macro FALSE_START_EN makes a press during COUNT disqualify the presser.
module round_arbiter #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int COUNT_SEC  = 3,
    parameter int ANSWER_SEC = 9,
    parameter int HOLD_SEC   = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_1P,
    input  logic       IN_2P,
    input  logic       ACK,
    output logic [1:0] phase,
    output logic [3:0] num,
    output logic [1:0] winner,
    output logic       tick
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_COUNT  = 2'b01;
    localparam logic [1:0] S_ANSWER = 2'b10;
    localparam logic [1:0] S_RESULT = 2'b11;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_1P   = 2'b01;
    localparam logic [1:0] W_2P   = 2'b10;
    localparam logic [1:0] W_VOID = 2'b11;

    localparam int             CW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(CLK_HZ - 1);
    localparam logic [3:0]     COUNT_N   = 4'(COUNT_SEC);
    localparam logic [3:0]     ANSWER_N  = 4'(ANSWER_SEC);
    localparam logic [3:0]     HOLD_LAST = 4'(HOLD_SEC - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;
    logic [3:0]    r_num;
    logic [1:0]    r_winner;
    logic [3:0]    r_hold;
    logic          r_tick;
    logic          r_prio_2p;
    logic          r_1p_d;
    logic          r_2p_d;

    logic          w_tick;
    logic          w_p1;
    logic          w_p2;
    logic [1:0]    w_phase_nx;
    logic [3:0]    w_num_nx;
    logic [1:0]    w_winner_nx;
    logic [3:0]    w_hold_nx;
    logic          w_prio_nx;
    logic          w_change;

    assign w_tick   = (r_cnt == TICK_LAST);
    assign w_p1     = IN_1P & ~r_1p_d;
    assign w_p2     = IN_2P & ~r_2p_d;
    assign w_change = (w_phase_nx != r_phase);

    always_comb begin
        w_phase_nx  = r_phase;
        w_num_nx    = r_num;
        w_winner_nx = r_winner;
        w_hold_nx   = r_hold;
        w_prio_nx   = r_prio_2p;
        case (r_phase)
            S_IDLE: begin
                w_num_nx    = 4'd0;
                w_winner_nx = W_NONE;
                if (IN_1P && IN_2P) begin
                    w_phase_nx = S_COUNT;
                    w_num_nx   = COUNT_N;
                end
            end
            S_COUNT: begin
`ifdef FALSE_START_EN
                if (w_p1 || w_p2) begin
                    w_phase_nx  = S_RESULT;
                    w_num_nx    = 4'd0;
                    w_hold_nx   = 4'd0;
                    w_winner_nx = (w_p1 && w_p2) ? W_VOID : (w_p1 ? W_2P : W_1P);
                end else
`endif
                if (w_tick) begin
                    if (r_num <= 4'd1) begin
                        w_phase_nx = S_ANSWER;
                        w_num_nx   = ANSWER_N;
                    end else begin
                        w_num_nx = r_num - 4'd1;
                    end
                end
            end
            S_ANSWER: begin
                // A press in the final-tick cycle still beats the timeout.
                if (w_p1 || w_p2) begin
                    w_phase_nx = S_RESULT;
                    w_num_nx   = 4'd0;
                    w_hold_nx  = 4'd0;
                    if (w_p1 && w_p2) begin
                        w_winner_nx = r_prio_2p ? W_1P : W_2P;
                        w_prio_nx   = ~r_prio_2p;
                    end else begin
                        w_winner_nx = w_p1 ? W_1P : W_2P;
                    end
                end else if (w_tick) begin
                    if (r_num <= 4'd1) begin
                        w_phase_nx  = S_RESULT;
                        w_num_nx    = 4'd0;
                        w_hold_nx   = 4'd0;
                        w_winner_nx = W_VOID;
                    end else begin
                        w_num_nx = r_num - 4'd1;
                    end
                end
            end
            default: begin
                w_num_nx = 4'd0;
                if (ACK || (w_tick && r_hold >= HOLD_LAST)) begin
                    w_phase_nx  = S_IDLE;
                    w_winner_nx = W_NONE;
                end else if (w_tick) begin
                    w_hold_nx = r_hold + 4'd1;
                end
            end
        endcase
    end

    // History regs reset high so a button held through reset produces no edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_phase   <= S_IDLE;
            r_num     <= 4'd0;
            r_winner  <= W_NONE;
            r_hold    <= 4'd0;
            r_tick    <= 1'b0;
            r_prio_2p <= 1'b1;
            r_1p_d    <= 1'b1;
            r_2p_d    <= 1'b1;
        end else begin
            r_cnt     <= (w_change || w_tick) ? '0 : r_cnt + CW'(1);
            r_phase   <= w_phase_nx;
            r_num     <= w_num_nx;
            r_winner  <= w_winner_nx;
            r_hold    <= w_hold_nx;
            r_tick    <= w_tick;
            r_prio_2p <= w_prio_nx;
            r_1p_d    <= IN_1P;
            r_2p_d    <= IN_2P;
        end
    end

    assign phase  = r_phase;
    assign num    = r_num;
    assign winner = r_winner;
    assign tick   = r_tick;

endmodule

// File: tb/tb_round_arbiter.sv
// Bench for round_arbiter: directed round scenarios plus random button traffic,
// compared every cycle against an elapsed-time reference model.
module tb_round_arbiter;

  localparam int CLK_HZ     = 10;
  localparam int COUNT_SEC  = 3;
  localparam int ANSWER_SEC = 5;
  localparam int HOLD_SEC   = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       IN_1P = 1'b0;
  logic       IN_2P = 1'b0;
  logic       ACK = 1'b0;
  logic [1:0] phase;
  logic [3:0] num;
  logic [1:0] winner;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  round_arbiter #(
    .CLK_HZ(CLK_HZ), .COUNT_SEC(COUNT_SEC), .ANSWER_SEC(ANSWER_SEC), .HOLD_SEC(HOLD_SEC)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_1P(IN_1P), .IN_2P(IN_2P), .ACK(ACK),
    .phase(phase), .num(num), .winner(winner), .tick(tick)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model: phase plus cycles elapsed since entering it
  int         m_phase = 0;
  int         m_el = 0;
  logic [1:0] m_win = 2'b00;
  bit         m_tick = 1'b0;
  bit         m_tie_1p = 1'b1;
  bit         m_d1 = 1'b1;
  bit         m_d2 = 1'b1;
  logic [1:0] exp_q[$];

  always @(posedge CLK or negedge RST) begin : model
    bit         p1, p2, bnd;
    int         nph;
    logic [1:0] nwin;
    if (!RST) begin
      m_phase = 0; m_el = 0; m_win = 2'b00; m_tick = 1'b0;
      m_tie_1p = 1'b1; m_d1 = 1'b1; m_d2 = 1'b1;
      exp_q.delete();
    end else begin
      p1 = IN_1P && !m_d1;
      p2 = IN_2P && !m_d2;
      m_d1 = IN_1P;
      m_d2 = IN_2P;
      bnd = (m_el % CLK_HZ) == CLK_HZ - 1;
      nph = m_phase;
      nwin = m_win;
      case (m_phase)
        0: if (IN_1P && IN_2P) nph = 1;
        1: begin
`ifdef FALSE_START_EN
          if (p1 || p2) begin
            nph = 3;
            nwin = (p1 && p2) ? 2'b11 : (p1 ? 2'b10 : 2'b01);
          end else
`endif
          if (m_el + 1 == COUNT_SEC * CLK_HZ) nph = 2;
        end
        2: begin
          if (p1 && p2) begin
            nph = 3; nwin = m_tie_1p ? 2'b01 : 2'b10; m_tie_1p = !m_tie_1p;
          end else if (p1) begin
            nph = 3; nwin = 2'b01;
          end else if (p2) begin
            nph = 3; nwin = 2'b10;
          end else if (m_el + 1 == ANSWER_SEC * CLK_HZ) begin
            nph = 3; nwin = 2'b11;
          end
        end
        default: if (ACK || m_el + 1 == HOLD_SEC * CLK_HZ) begin nph = 0; nwin = 2'b00; end
      endcase
      m_tick = bnd;
      if (nph == 3 && m_phase != 3) exp_q.push_back(nwin);
      m_el = (nph != m_phase) ? 0 : m_el + 1;
      m_phase = nph;
      m_win = nwin;
    end
  end

  function automatic int model_num();
    if (m_phase == 1) return COUNT_SEC - m_el / CLK_HZ;
    if (m_phase == 2) return ANSWER_SEC - m_el / CLK_HZ;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  // scoreboard: per-cycle outputs plus the winner queue on each RESULT entry
  logic [1:0] prev_phase = 2'b00;

  task automatic compare_all();
    check("phase", phase, m_phase);
    check("num", num, model_num());
    check("winner", winner, m_win);
    check("tick", tick, m_tick);
    if (phase == 2'b11 && prev_phase != 2'b11) begin
      check("sb_pending", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
      if (exp_q.size() != 0) check("sb_winner", winner, exp_q.pop_front());
    end
    prev_phase = phase;
  endtask

  // driver tasks
  task automatic cycle(input logic a, input logic b, input logic k);
    @(negedge CLK);
    compare_all();
    IN_1P = a; IN_2P = b; ACK = k;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input logic [1:0] p, input int budget);
    int n;
    n = 0;
    while (phase != p && n < budget) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("reach_phase", phase, p);
  endtask

  task automatic start_round_to_answer();
    cycle(1'b1, 1'b1, 1'b0);
    run_until(2'b10, 100);
  endtask

  initial begin
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    check("rst_phase", phase, 0);
    check("rst_num", num, 0);
    check("rst_winner", winner, 0);
    check("rst_tick", tick, 0);

    // round start and countdown
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t1_phase", phase, 1);
    check("t1_num", num, 3);
    run_until(2'b10, 40);

    // 2P wins, then automatic return after the hold time
    idle(4);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t2_phase", phase, 3);
    check("t2_winner", winner, 2);
    idle(24);
    check("t2_idle", phase, 0);

    // ties alternate 1P then 2P
    start_round_to_answer();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_tie1", winner, 1);
    cycle(1'b0, 1'b0, 1'b1);
    start_round_to_answer();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t3_tie2", winner, 2);
    cycle(1'b0, 1'b0, 1'b1);

    // no press: timeout, then early ACK
    start_round_to_answer();
    idle(52);
    check("t4_winner", winner, 3);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1);
    idle(2);

    // press during the countdown
    cycle(1'b1, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
`ifdef FALSE_START_EN
    check("t6_phase", phase, 3);
    check("t6_winner", winner, 2);
`else
    check("t6_phase", phase, 1);
`endif
    run_until(2'b00, 200);

    // asynchronous reset mid-ANSWER, released with 1P held
    start_round_to_answer();
    cycle(1'b1, 1'b0, 1'b0);
    #2 RST = 1'b0;
    #1;
    check("t5_phase", phase, 0);
    check("t5_num", num, 0);
    check("t5_winner", winner, 0);
    check("t5_tick", tick, 0);
    prev_phase = 2'b00;
    cycle(1'b1, 1'b0, 1'b0);
    #2 RST = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    check("t5_stay", phase, 0);
    cycle(1'b0, 1'b0, 1'b0);

    // random button traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 7) == 0) b = ~b;
      cycle(a, b, ($urandom_range(0, 39) == 0));
    end
    idle(60);
    check("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
